// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (Booth radix-2) / divide (restoring) unit.
// One step per cycle; HI/LO results are held until the next completion.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH);
    localparam int AW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             op_q, sa_q, sb_q, dz_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] mcand_q, hi_q, lo_q, hi_d, lo_d;
    logic [AW-1:0]    acc_q, acc_d;

    logic [WIDTH-1:0] a_abs, b_abs, quo, rem;
    logic [WIDTH:0]   p_ext, m_ext, sum, r_shift, trial;
    logic             last_step, div_by_zero;

    assign a_abs       = a_i[WIDTH-1] ? -a_i : a_i;
    assign b_abs       = b_i[WIDTH-1] ? -b_i : b_i;
    assign div_by_zero = op_i && (b_i == '0);
    assign last_step   = (cnt_q == CW'(WIDTH - 1));

    // Booth: acc = {P_hi, P_lo, q-1}; the W+1-bit sum keeps the true sign for the shift.
    // Divide: acc = {R (W+1 bits), Q (W bits)}.
    always_comb begin
        acc_d   = acc_q;
        p_ext   = {acc_q[AW-1], acc_q[AW-1:WIDTH+1]};
        m_ext   = {mcand_q[WIDTH-1], mcand_q};
        sum     = p_ext;
        r_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        trial   = r_shift - {1'b0, mcand_q};
        if (!op_q) begin
            case (acc_q[1:0])
                2'b01:   sum = p_ext + m_ext;
                2'b10:   sum = p_ext - m_ext;
                default: sum = p_ext;
            endcase
            acc_d = {sum, acc_q[WIDTH:1]};
        end else if (!trial[WIDTH]) begin
            acc_d = {trial, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {r_shift, acc_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        quo = acc_d[WIDTH-1:0];
        rem = acc_d[2*WIDTH-1:WIDTH];
        if (!op_q) begin
            hi_d = acc_d[AW-1:WIDTH+1];
            lo_d = acc_d[WIDTH:1];
        end else begin
            hi_d = sa_q ? -rem : rem;
            lo_d = (sa_q ^ sb_q) ? -quo : quo;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = div_by_zero ? S_DONE : S_RUN;
            S_RUN:   if (last_step) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state_q == S_RUN);
        done_o     = (state_q == S_DONE);
        div_zero_o = (state_q == S_DONE) && dz_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            op_q    <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        op_q    <= op_i;
                        sa_q    <= a_i[WIDTH-1];
                        sb_q    <= b_i[WIDTH-1];
                        dz_q    <= div_by_zero;
                        cnt_q   <= '0;
                        mcand_q <= op_i ? b_abs : a_i;
                        acc_q   <= op_i ? {{(WIDTH+1){1'b0}}, a_abs}
                                        : {{WIDTH{1'b0}}, b_i, 1'b0};
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_step) begin
                        hi_q <= hi_d;
                        lo_q <= lo_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (WIDTH = 32).
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset, start, op;
    logic [31:0] a, b;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;
    int          total = 0;
    int          bad = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .op_i(op),
        .a_i(a), .b_i(b), .busy_o(busy), .done_o(done),
        .div_zero_o(div_zero), .hi_o(hi), .lo_o(lo)
    );

    always #5 clk = ~clk;

    // Pulse start in an IDLE cycle, scramble a/b after the start edge, and
    // return the cycle (1 = first after the start edge) in which done appears.
    task automatic run_op(input logic o, input logic [31:0] av, input logic [31:0] bv,
                          output int cyc, output int bcnt, output logic dz);
        @(negedge clk);
        op = o; a = av; b = bv; start = 1'b1;
        cyc = -1; bcnt = 0; dz = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start = 1'b0; a = ~av; b = bv ^ 32'h5A5A_0F0F; op = ~o;
            if (busy) bcnt++;
            if (done) begin
                cyc = n; dz = div_zero;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, div_zero} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, div_zero});
        end
        total++;
        if ({hi, lo} !== 64'h0) begin
            bad++; $display("FAIL reset_hilo got=%h want=0", {hi, lo});
        end
    endtask

    task automatic test_mult();
        int cyc, bc; logic dz;
        logic [31:0] av[4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        logic [31:0] bv[4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [63:0] ex[4] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000,
                               64'h0000_0000_0000_0001, 64'hC000_0000_8000_0000};
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, av[i], bv[i], cyc, bc, dz);
            total++;
            if (cyc !== 33 || bc !== 32) begin
                bad++; $display("FAIL mult%0d_timing got cyc=%0d busy=%0d want 33/32", i, cyc, bc);
            end
            total++;
            if ({hi, lo} !== ex[i] || dz !== 1'b0) begin
                bad++; $display("FAIL mult%0d_result got=%h dz=%b want=%h dz=0", i, {hi, lo}, dz, ex[i]);
            end
        end
    endtask

    task automatic test_div();
        int cyc, bc; logic dz;
        logic [31:0] av[5] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd7, 32'hFFFF_FFF9};
        logic [31:0] bv[5] = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [63:0] ex[5] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0002_0000_000E,
                               64'h0000_0000_8000_0000, 64'h0000_0001_FFFF_FFFD,
                               64'hFFFF_FFFF_0000_0003};
        for (int i = 0; i < 5; i++) begin
            run_op(1'b1, av[i], bv[i], cyc, bc, dz);
            total++;
            if (cyc !== 33 || bc !== 32) begin
                bad++; $display("FAIL div%0d_timing got cyc=%0d busy=%0d want 33/32", i, cyc, bc);
            end
            total++;
            if ({hi, lo} !== ex[i] || dz !== 1'b0) begin
                bad++; $display("FAIL div%0d_result got=%h dz=%b want=%h dz=0", i, {hi, lo}, dz, ex[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int cyc, bc; logic dz;
        run_op(1'b1, 32'd100, 32'd7, cyc, bc, dz);
        run_op(1'b1, 32'd5, 32'd0, cyc, bc, dz);
        total++;
        if (cyc !== 1 || bc !== 0 || dz !== 1'b1) begin
            bad++; $display("FAIL divzero_timing got cyc=%0d busy=%0d dz=%b want 1/0/1", cyc, bc, dz);
        end
        total++;
        if ({hi, lo} !== 64'h0000_0002_0000_000E) begin
            bad++; $display("FAIL divzero_hold got=%h want=000000020000000e", {hi, lo});
        end
        @(negedge clk);
        total++;
        if ({busy, done, div_zero} !== 3'b000) begin
            bad++; $display("FAIL divzero_after got=%b want=000", {busy, done, div_zero});
        end
    endtask

    task automatic test_start_ignored();
        int cyc = -1;
        @(negedge clk);
        op = 1'b0; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start = (n == 10);
            if (n == 10) begin op = 1'b1; a = 32'd9; b = 32'd0; end
            if (done) begin cyc = n; break; end
        end
        // start held high during the DONE cycle must also be ignored
        start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd3;
        total++;
        if (cyc !== 33 || {hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB || div_zero !== 1'b0) begin
            bad++; $display("FAIL ignore_run got cyc=%0d res=%h dz=%b want 33/ffffffffffffffeb/0",
                            cyc, {hi, lo}, div_zero);
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL ignore_done got busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc, bc; logic dz; int dones = 0;
        @(negedge clk);
        op = 1'b0; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || {hi, lo} !== 64'h0) begin
            bad++; $display("FAIL reset_mid got busy=%b done=%b res=%h want 0/0/0", busy, done, {hi, lo});
        end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++; $display("FAIL reset_no_done got activity=%0d want=0", dones);
        end
        run_op(1'b1, 32'd100, 32'd7, cyc, bc, dz);
        total++;
        if (cyc !== 33 || {hi, lo} !== 64'h0000_0002_0000_000E) begin
            bad++; $display("FAIL reset_fresh got cyc=%0d res=%h want 33/000000020000000e", cyc, {hi, lo});
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_start_ignored();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
